// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : i2s_transmitter
// Purpose : Serialises stereo 16-bit PCM into I2S, with an internal BCLK/LRCLK
//           divider and a one-deep sample holding register.
//           Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing.
// Revision: 1.0
// ============================================================================
module i2s_transmitter #(
  parameter int unsigned CLK_DIV_HALF = 12,
  parameter int unsigned SLOT_BITS    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] left_sample_in,
  input  logic [15:0] right_sample_in,
  input  logic        sample_valid_in,
  output logic        i2s_bclk_out,
  output logic        i2s_lrclk_out,
  output logic        i2s_data_out,
  output logic        frame_start_out,
  output logic        underrun_out,
  output logic        overrun_out
);

  localparam int unsigned CNT_W    = $clog2(2 * SLOT_BITS);
  localparam int unsigned SLOT_W   = $clog2(SLOT_BITS);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV_HALF - 1);

  logic [7:0]       div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]      hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic [15:0]      shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic             lrclk_q, lrclk_d, data_q, data_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d, overrun_q, overrun_d;

  logic              w_wrap, w_fall, w_load, w_tx_bit;
  logic [15:0]       w_word;
  logic [SLOT_W-1:0] w_slot_pos;

  always_comb begin
    w_wrap = (div_q == DIV_LAST);
    w_fall = w_wrap & bclk_q;
    w_load = w_fall & (bit_cnt_q == '1);

    div_d     = w_wrap ? 8'd0 : div_q + 8'd1;
    bclk_d    = w_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = w_fall ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;

    shift_l_d = (w_load && hold_full_q) ? hold_l_q : shift_l_q;
    shift_r_d = (w_load && hold_full_q) ? hold_r_q : shift_r_q;

    // A capture coincident with a frame load refills the slot the load just emptied.
    hold_l_d    = sample_valid_in ? left_sample_in  : hold_l_q;
    hold_r_d    = sample_valid_in ? right_sample_in : hold_r_q;
    hold_full_d = sample_valid_in ? 1'b1 : (w_load ? 1'b0 : hold_full_q);

    w_word     = bit_cnt_d[CNT_W-1] ? shift_r_d : shift_l_d;
    w_slot_pos = bit_cnt_d[SLOT_W-1:0];
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    w_tx_bit = (w_slot_pos < SLOT_W'(16)) ? w_word[4'(SLOT_W'(15) - w_slot_pos)] : 1'b0;
`else
    w_tx_bit = ((w_slot_pos != '0) && (w_slot_pos <= SLOT_W'(16)))
             ? w_word[4'(SLOT_W'(16) - w_slot_pos)] : 1'b0;
`endif

    lrclk_d       = w_fall ? bit_cnt_d[CNT_W-1] : lrclk_q;
    data_d        = w_fall ? w_tx_bit : data_q;
    frame_start_d = w_load;
    underrun_d    = w_load & ~hold_full_q;
    overrun_d     = sample_valid_in & hold_full_q & ~w_load;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q         <= 8'd0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= '1;
      hold_l_q      <= 16'd0;
      hold_r_q      <= 16'd0;
      hold_full_q   <= 1'b0;
      shift_l_q     <= 16'd0;
      shift_r_q     <= 16'd0;
      lrclk_q       <= 1'b0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      lrclk_q       <= lrclk_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign i2s_bclk_out    = bclk_q;
  assign i2s_lrclk_out   = lrclk_q;
  assign i2s_data_out    = data_q;
  assign frame_start_out = frame_start_q;
  assign underrun_out    = underrun_q;
  assign overrun_out     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_transmitter
// Purpose : Self-checking bench for i2s_transmitter; every output is compared
//           each clock against a clock-count based reference model.
// Revision: 1.0
// ============================================================================
module tb_i2s_transmitter;

  localparam int DIV        = 12;
  localparam int FALL_CLKS  = 2 * DIV;
  localparam int FRAME_CLKS = FALL_CLKS * 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] left_sample_in = 16'd0;
  logic [15:0] right_sample_in = 16'd0;
  logic        sample_valid_in = 1'b0;
  logic        i2s_bclk_out, i2s_lrclk_out, i2s_data_out;
  logic        frame_start_out, underrun_out, overrun_out;

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(.CLK_DIV_HALF(DIV), .SLOT_BITS(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .left_sample_in  (left_sample_in),
    .right_sample_in (right_sample_in),
    .sample_valid_in (sample_valid_in),
    .i2s_bclk_out    (i2s_bclk_out),
    .i2s_lrclk_out   (i2s_lrclk_out),
    .i2s_data_out    (i2s_data_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out),
    .overrun_out     (overrun_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: t = clock edges since reset release.
  int          t = 0;
  logic [15:0] m_tx_l = 16'd0, m_tx_r = 16'd0, m_hold_l = 16'd0, m_hold_r = 16'd0;
  logic        m_full = 1'b0;
  logic        e_bclk = 1'b0, e_lr = 1'b0, e_data = 1'b0;
  logic        e_fs = 1'b0, e_ur = 1'b0, e_or = 1'b0;

  task automatic model_edge(input logic rst, input logic v,
                            input logic [15:0] l, input logic [15:0] r);
    int m, b, s;
    logic [15:0] w;
    if (rst) begin
      t = 0;
      m_tx_l = 16'd0; m_tx_r = 16'd0; m_hold_l = 16'd0; m_hold_r = 16'd0;
      m_full = 1'b0;
      e_bclk = 1'b0; e_lr = 1'b0; e_data = 1'b0;
      e_fs = 1'b0; e_ur = 1'b0; e_or = 1'b0;
      return;
    end
    t++;
    e_fs = 1'b0; e_ur = 1'b0; e_or = 1'b0;
    e_bclk = (((t / DIV) % 2) == 1);
    if ((t % FALL_CLKS) == 0) begin
      m = t / FALL_CLKS;
      b = (m - 1) % 64;
      s = b % 32;
      if (b == 0) begin
        e_fs = 1'b1;
        if (m_full) begin
          m_tx_l = m_hold_l; m_tx_r = m_hold_r; m_full = 1'b0;
        end else begin
          e_ur = 1'b1;
        end
      end
      e_lr = (b >= 32);
      w = e_lr ? m_tx_r : m_tx_l;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      e_data = (s < 16) ? w[15 - s] : 1'b0;
`else
      e_data = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
`endif
    end
    if (v) begin
      if (m_full) e_or = 1'b1;
      m_hold_l = l; m_hold_r = r; m_full = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v,
                      input logic [15:0] l, input logic [15:0] r);
    rst_in = rst; sample_valid_in = v; left_sample_in = l; right_sample_in = r;
    @(posedge clk_in);
    model_edge(rst, v, l, r);
    #1;
    chk("bclk",        i2s_bclk_out,    e_bclk);
    chk("lrclk",       i2s_lrclk_out,   e_lr);
    chk("data",        i2s_data_out,    e_data);
    chk("frame_start", frame_start_out, e_fs);
    chk("underrun",    underrun_out,    e_ur);
    chk("overrun",     overrun_out,     e_or);
    rst_in = 1'b0; sample_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  function automatic int next_load(input int now);
    if (now < FALL_CLKS) return FALL_CLKS;
    return FALL_CLKS + ((now - FALL_CLKS) / FRAME_CLKS + 1) * FRAME_CLKS;
  endfunction

  initial begin
    int ld;
    // Reset, then two silent frames: underrun every frame, data 0.
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(2 * FRAME_CLKS + 30);

    // Sample captured one cycle before a frame load.
    ld = next_load(t);
    idle(ld - 2 - t);
    step(1'b0, 1'b1, 16'hA5C3, 16'h8001);
    idle(FRAME_CLKS + 40);

    // Two strobes 10 clocks apart inside one frame: overrun on the second.
    ld = next_load(t);
    idle(ld + 100 - t);
    step(1'b0, 1'b1, 16'h1111, 16'h3333);
    idle(9);
    step(1'b0, 1'b1, 16'h2222, 16'h4444);
    idle(next_load(t) - t + FRAME_CLKS);

    // Strobe on the frame-load edge with an empty holding register.
    ld = next_load(t);
    idle(ld - 1 - t);
    step(1'b0, 1'b1, 16'h5A5A, 16'h0F0F);
    idle(2 * FRAME_CLKS + 10);

    // MSB-only sample (exercises the left-justified slot-0 bit when enabled).
    ld = next_load(t);
    idle(ld - 200 - t);
    step(1'b0, 1'b1, 16'h8000, 16'h0000);
    idle(FRAME_CLKS + 250);

    // Mid-frame reset at bit_cnt 40 with a pending sample.
    ld = next_load(t);
    idle(ld - 50 - t);
    step(1'b0, 1'b1, 16'hBEEF, 16'hCAFE);
    idle(ld + 40 * FALL_CLKS - t);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(FRAME_CLKS + 60);

    // Randomised strobes and sample values.
    for (int i = 0; i < 6 * FRAME_CLKS; i++) begin
      if ($urandom_range(0, 699) == 0)
        step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      else
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
